cache_traffic_gen: RTL

CACHE_TRAFFIC_GEN -- requirements
Module: cache_traffic_gen

---
 rtl/cache_traffic_gen.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cache_traffic_gen.sv
// rtl/cache_traffic_gen.sv - LFSR-driven cache request generator with shadow-memory read checking
module cache_traffic_gen #(
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_REQ      = 10000,
  parameter int unsigned WRITE_THRESH = 64,
  parameter logic [31:0] SEED         = 32'h075BCD14,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic                  cpu_read,
  output logic                  cpu_write,
  input  logic [DATA_WIDTH-1:0] cpu_data_out,
  input  logic                  cpu_ready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  req_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  max_latency,
  output logic [CNT_WIDTH-1:0]  total_latency,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int unsigned          DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [31:0]          TAPS      = 32'h80200003;
  localparam logic [31:0]          SEED_C    = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [8:0]           THRESH_C  = 9'(WRITE_THRESH);
  localparam logic [CNT_WIDTH-1:0] NUM_REQ_C = CNT_WIDTH'(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = 1;

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             lfsr_q, lfsr_d, lfsr_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    wr_q, wr_d;
  logic [CNT_WIDTH-1:0]    wait_q, wait_d;
  logic [CNT_WIDTH-1:0]    req_q, req_d;
  logic [CNT_WIDTH-1:0]    err_q, err_d;
  logic [CNT_WIDTH-1:0]    max_q, max_d;
  logic [CNT_WIDTH-1:0]    tot_q, tot_d;
  logic [ADDR_WIDTH-1:0]   ferr_q, ferr_d;
  logic                    seen_q, seen_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   shadow_mem [DEPTH];

  logic                    run_start, wait_hit, wait_to, complete, is_err, last, mem_we;
  logic [CNT_WIDTH-1:0]    lat;
  logic [CNT_WIDTH:0]      tot_sum;

  assign lfsr_nxt  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'd0);
  assign run_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign lat       = wait_q + CNT_ONE;
  // The issue cycle never looks at cpu_ready; only WAIT cycles can complete.
  assign wait_hit  = (state_q == S_WAIT) && cpu_ready;
  assign wait_to   = (state_q == S_WAIT) && !cpu_ready && (lat == TIMEOUT_C);
  assign complete  = wait_hit || wait_to;
  assign is_err    = wait_to ||
                     (wait_hit && !wr_q && valid_q[addr_q] && (cpu_data_out != shadow_mem[addr_q]));
  assign last      = (req_q + CNT_ONE) == NUM_REQ_C;
  assign tot_sum   = {1'b0, tot_q} + {1'b0, lat};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_GEN;
      S_GEN:   state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (complete) state_d = last ? S_DONE : S_GEN;
      S_DONE:  if (start) state_d = S_GEN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_addr       = addr_q;
    cpu_data_in    = data_q;
    cpu_read       = (state_q == S_ISSUE) && !wr_q;
    cpu_write      = (state_q == S_ISSUE) && wr_q;
    busy           = (state_q == S_GEN) || (state_q == S_ISSUE) || (state_q == S_WAIT);
    done           = (state_q == S_DONE);
    req_count      = req_q;
    err_count      = err_q;
    max_latency    = max_q;
    total_latency  = tot_q;
    first_err_addr = ferr_q;
  end

  always_comb begin
    lfsr_d  = lfsr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    wait_d  = wait_q;
    req_d   = req_q;
    err_d   = err_q;
    max_d   = max_q;
    tot_d   = tot_q;
    ferr_d  = ferr_q;
    seen_d  = seen_q;
    valid_d = valid_q;
    mem_we  = 1'b0;
    if (run_start) begin
      req_d   = '0;
      err_d   = '0;
      max_d   = '0;
      tot_d   = '0;
      ferr_d  = '0;
      seen_d  = 1'b0;
      valid_d = '0;
    end
    if (state_q == S_GEN) begin
      lfsr_d = lfsr_nxt;
      addr_d = lfsr_nxt[ADDR_WIDTH-1:0];
      data_d = lfsr_nxt[ADDR_WIDTH+DATA_WIDTH-1:ADDR_WIDTH];
      wr_d   = {1'b0, lfsr_nxt[31:24]} < THRESH_C;
      wait_d = '0;
    end
    if (state_q == S_WAIT) begin
      wait_d = lat;
    end
    if (complete) begin
      req_d = req_q + CNT_ONE;
      tot_d = tot_sum[CNT_WIDTH] ? '1 : tot_sum[CNT_WIDTH-1:0];
      if (lat > max_q) max_d = lat;
      // A timed-out write never reached the cache, so the shadow stays untouched.
      if (wait_hit && wr_q) begin
        valid_d[addr_q] = 1'b1;
        mem_we          = 1'b1;
      end
      if (is_err) begin
        err_d = err_q + CNT_ONE;
        if (!seen_q) begin
          seen_d = 1'b1;
          ferr_d = addr_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= SEED_C;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      wait_q  <= '0;
      req_q   <= '0;
      err_q   <= '0;
      max_q   <= '0;
      tot_q   <= '0;
      ferr_q  <= '0;
      seen_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      err_q   <= err_d;
      max_q   <= max_d;
      tot_q   <= tot_d;
      ferr_q  <= ferr_d;
      seen_q  <= seen_d;
      valid_q <= valid_d;
    end
  end

  // Shadow data needs no reset: entries are only trusted once their valid bit is set.
  always_ff @(posedge clk) begin
    if (mem_we) shadow_mem[addr_q] <= data_q;
  end

endmodule
